// File: rtl/ball_motion_sequencer.sv
// Per-frame metaball animator: on each vsync, steps every ball through one shared
// add/compare unit, then commits the whole frame to the live bank in a single cycle.
module ball_motion_sequencer #(
    parameter int unsigned NUM_BALLS        = 3,
    parameter int unsigned SCREEN_WIDTH     = 640,
    parameter int unsigned SCREEN_HEIGHT    = 480,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pause,
    input  logic       step,
    input  logic [1:0] speed,
    input  logic [1:0] rd_idx,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] frame_cnt
);
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ARITH_W = 12;
    localparam int unsigned IDX_W   = 2;
    localparam logic [ARITH_W-1:0] MAX_X    = ARITH_W'(SCREEN_WIDTH - 1);
    localparam logic [ARITH_W-1:0] MAX_Y    = ARITH_W'(SCREEN_HEIGHT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BALLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STEP_X,
        STEP_Y,
        STORE,
        COMMIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [COORD_W-1:0] live_x    [NUM_BALLS];
    logic [COORD_W-1:0] live_y    [NUM_BALLS];
    logic [COORD_W-1:0] work_x    [NUM_BALLS];
    logic [COORD_W-1:0] work_y    [NUM_BALLS];
    logic               work_xneg [NUM_BALLS];
    logic               work_yneg [NUM_BALLS];

    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               cur_xneg;
    logic               cur_yneg;
    logic [1:0]         spd;
    logic [IDX_W-1:0]   ball_idx;

    logic vsync_act;
    logic vsync_prev;
    logic tick;
    logic trig;
    logic running;
    logic busy_d;
    logic done_d;

    // History holds the normalised (active-high) vsync level
    assign vsync_act = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign tick      = vsync_act & ~vsync_prev;
    assign trig      = (tick & ~pause) | step;
    assign running   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE:    if (trig) next_state = FETCH;
            FETCH:   next_state = STEP_X;
            STEP_X:  next_state = STEP_Y;
            STEP_Y:  next_state = STORE;
            STORE:   next_state = (ball_idx == LAST_IDX) ? COMMIT : FETCH;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        busy_d = (next_state != IDLE);
        done_d = (next_state == COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Shared add/compare unit: one reflecting step on whichever axis is active
    logic [ARITH_W-1:0] base_x;
    logic [ARITH_W-1:0] base_y;
    logic [ARITH_W-1:0] op_c;
    logic [ARITH_W-1:0] op_m;
    logic [ARITH_W-1:0] op_max;
    logic [ARITH_W-1:0] sum;
    logic [ARITH_W-1:0] res_c;
    logic               op_neg;
    logic               op_is_y;
    logic               res_neg;

    always_comb begin
        op_is_y = (state == STEP_Y);
        base_x  = ARITH_W'(ball_idx) + ARITH_W'(1);
        base_y  = ARITH_W'(ball_idx) + ARITH_W'(2);
        op_c    = op_is_y ? ARITH_W'(cur_y) : ARITH_W'(cur_x);
        op_m    = (op_is_y ? base_y : base_x) << spd;
        op_neg  = op_is_y ? cur_yneg : cur_xneg;
        op_max  = op_is_y ? MAX_Y : MAX_X;
        sum     = op_c + op_m;
        res_c   = sum;
        res_neg = op_neg;
        if (!op_neg) begin
            if (sum > op_max) begin
                res_c   = (op_max << 1) - sum;
                res_neg = 1'b1;
            end
        end else if (op_c < op_m) begin
            res_c   = op_m - op_c;
            res_neg = 1'b0;
        end else begin
            res_c = op_c - op_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                work_x[i]    <= COORD_W'(100 + 160 * i);
                work_y[i]    <= COORD_W'(120 + 80 * i);
                live_x[i]    <= COORD_W'(100 + 160 * i);
                live_y[i]    <= COORD_W'(120 + 80 * i);
                work_xneg[i] <= 1'b0;
                work_yneg[i] <= 1'b1;
            end
            cur_x      <= '0;
            cur_y      <= '0;
            cur_xneg   <= 1'b0;
            cur_yneg   <= 1'b0;
            spd        <= '0;
            ball_idx   <= '0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync_act;
            if (trig && running) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (trig) begin
                        spd      <= speed;
                        ball_idx <= '0;
                    end
                end
                FETCH: begin
                    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                        if (ball_idx == IDX_W'(i)) begin
                            cur_x    <= work_x[i];
                            cur_y    <= work_y[i];
                            cur_xneg <= work_xneg[i];
                            cur_yneg <= work_yneg[i];
                        end
                    end
                end
                STEP_X: begin
                    cur_x    <= COORD_W'(res_c);
                    cur_xneg <= res_neg;
                end
                STEP_Y: begin
                    cur_y    <= COORD_W'(res_c);
                    cur_yneg <= res_neg;
                end
                STORE: begin
                    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                        if (ball_idx == IDX_W'(i)) begin
                            work_x[i]    <= cur_x;
                            work_y[i]    <= cur_y;
                            work_xneg[i] <= cur_xneg;
                            work_yneg[i] <= cur_yneg;
                        end
                    end
                    if (ball_idx != LAST_IDX) ball_idx <= ball_idx + IDX_W'(1);
                end
                COMMIT: begin
                    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                        live_x[i] <= work_x[i];
                        live_y[i] <= work_y[i];
                    end
                    frame_cnt <= frame_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Renderer read port; unpopulated indices read as the origin
    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_x = live_x[i];
                rd_y = live_y[i];
            end
        end
    end

endmodule
